// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   function automatic arb_state_t own_state(input logic port);
      return port ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage

// File: rtl/arb_next_owner.sv
// Combinational next-owner decision for the memory port arbiter:
// next state, next last_served and next hold count from the current registered view.
module arb_next_owner
   import mem_arb_pkg::*;
#(
   parameter int unsigned FIXED_PRI = 0,
   parameter int unsigned MAX_HOLD  = 8
) (
   input  logic [1:0]                       state,
   input  logic [1:0]                       reqs,
   input  logic [1:0]                       locks,
   input  logic                             last_served,
   input  logic [$clog2(MAX_HOLD+1)-1:0]    hold_cnt,
   output logic [1:0]                       next_state,
   output logic                             next_last_served,
   output logic [$clog2(MAX_HOLD+1)-1:0]    next_hold_cnt
);
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_t cur;
   arb_state_t nxt;
   logic       own;
   logic       oth;
   logic       hold_lim;

   always_comb begin
      cur              = arb_state_t'(state);
      nxt              = ST_IDLE;
      own              = (cur == ST_OWN1);
      oth              = ~own;
      hold_lim         = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
      next_last_served = last_served;
      next_hold_cnt    = '0;

      case (cur)
         ST_IDLE: begin
            if (reqs[P0] && reqs[P1])
               nxt = (FIXED_PRI != 0) ? ST_OWN0 : own_state(~last_served);
            else if (reqs[P0])
               nxt = ST_OWN0;
            else if (reqs[P1])
               nxt = ST_OWN1;
         end
         ST_OWN0, ST_OWN1: begin
            // Hold limit overrides lock so a waiting port is never starved.
            if ((FIXED_PRI != 0) && (cur == ST_OWN1) && reqs[P0] && !locks[P1])
               nxt = ST_OWN0;
            else if (reqs[own] && (locks[own] || !reqs[oth]) && !(reqs[oth] && hold_lim))
               nxt = cur;
            else if (reqs[oth])
               nxt = own_state(oth);
            else
               nxt = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase

      if ((cur != ST_IDLE) && (nxt != cur))
         next_last_served = own;
      if ((cur != ST_IDLE) && (nxt == cur))
         next_hold_cnt = (reqs[own] && reqs[oth] && !hold_lim) ? hold_cnt + 1'b1 : hold_cnt;

      next_state = nxt;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-RAM port between the core (port 0) and a secondary master (port 1).
// Ownership is registered; grants and the memory mux follow the current owner combinationally.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned FIXED_PRI = 0,
   parameter int unsigned MAX_HOLD  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_lock,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_lock,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_t        state;
   logic              last_served;
   logic [HOLD_W-1:0] hold_cnt;
   logic [1:0]        next_state;
   logic              next_last_served;
   logic [HOLD_W-1:0] next_hold_cnt;

   arb_next_owner #(
      .FIXED_PRI (FIXED_PRI),
      .MAX_HOLD  (MAX_HOLD)
   ) u_next_owner (
      .state            (state),
      .reqs             ({p1_req, p0_req}),
      .locks            ({p1_lock, p0_lock}),
      .last_served      (last_served),
      .hold_cnt         (hold_cnt),
      .next_state       (next_state),
      .next_last_served (next_last_served),
      .next_hold_cnt    (next_hold_cnt)
   );

   assign p0_gnt   = (state == ST_OWN0) & p0_req;
   assign p1_gnt   = (state == ST_OWN1) & p1_req;
   assign p0_rdata = mem_rdata;
   assign p1_rdata = mem_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_served <= P1;
         hold_cnt    <= '0;
         p0_rvalid   <= 1'b0;
         p1_rvalid   <= 1'b0;
      end else begin
         state       <= arb_state_t'(next_state);
         last_served <= next_last_served;
         hold_cnt    <= next_hold_cnt;
         p0_rvalid   <= p0_gnt & ~p0_we;
         p1_rvalid   <= p1_gnt & ~p1_we;
      end
   end

   // Write enable is gated by the grant, so a dropped request never writes.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state)
         ST_OWN0: begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_we    = p0_gnt & p0_we;
         end
         ST_OWN1: begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_we    = p1_gnt & p1_we;
         end
         default: ;
      endcase
   end

endmodule
